// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB encodings and helpers for the bus arbiter slice.
//   htrans_t    : transfer type of the address-phase owner
//   hburst_t    : burst type of the address-phase owner
//   arb_state_t : arbiter sequencing state
//   burst_beats : beats-1 for fixed-length bursts, 0 for SINGLE/INCR
//   onehot_to_idx : index of a 3-bit one-hot vector (0 when not one-hot)
// ----------------------------------------------------------------------------
package ahb_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HB_SINGLE = 3'b000,
      HB_INCR   = 3'b001,
      HB_WRAP4  = 3'b010,
      HB_INCR4  = 3'b011,
      HB_WRAP8  = 3'b100,
      HB_INCR8  = 3'b101,
      HB_WRAP16 = 3'b110,
      HB_INCR16 = 3'b111
   } hburst_t;

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      BURST  = 2'd1,
      LOCKED = 2'd2
   } arb_state_t;

   // Remaining beats after the NONSEQ beat; zero means "not a fixed burst".
   function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
      case (hburst)
         HB_WRAP4,  HB_INCR4:  burst_beats = 4'd3;
         HB_WRAP8,  HB_INCR8:  burst_beats = 4'd7;
         HB_WRAP16, HB_INCR16: burst_beats = 4'd15;
         default:              burst_beats = 4'd0;
      endcase
   endfunction

   function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
      case (oh)
         3'b010:  onehot_to_idx = 2'd1;
         3'b100:  onehot_to_idx = 2'd2;
         default: onehot_to_idx = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// ----------------------------------------------------------------------------
// ahb_arbiter_if
// Arbitration signals shared between the masters and the arbiter.
//   HBUSREQ/HLOCK : per-master request and lock
//   HTRANS/HBURST : transfer and burst type of the current address owner
//   HREADY        : global transfer-done from the slave response mux
//   HGRANT        : one-hot grant
//   HMASTER       : address-phase owner, HMASTER_D : data-phase owner
//   HMASTLOCK     : current address phase is locked
// modport slave is the arbiter side, modport master the requesting side.
// ----------------------------------------------------------------------------
interface ahb_arbiter_if;

   logic [2:0] HBUSREQ;
   logic [2:0] HLOCK;
   logic [1:0] HTRANS;
   logic [2:0] HBURST;
   logic       HREADY;
   logic [2:0] HGRANT;
   logic [1:0] HMASTER;
   logic [1:0] HMASTER_D;
   logic       HMASTLOCK;

   modport slave (
      input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
      output HGRANT, HMASTER, HMASTER_D, HMASTLOCK
   );

   modport master (
      output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
      input  HGRANT, HMASTER, HMASTER_D, HMASTLOCK
   );

endinterface

// File: rtl/rr_pick3.sv
// ----------------------------------------------------------------------------
// rr_pick3
// Combinational round-robin selector for three requesters. The search order
// starts just after the pointer: ptr+1, ptr+2, ptr+3 (mod 3).
//   req        : request vector
//   ptr        : index of the most recently granted requester
//   gnt_onehot : one-hot winner (zero when no request)
//   valid      : at least one request present
// ----------------------------------------------------------------------------
module rr_pick3 (
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] gnt_onehot,
   output logic       valid
);

   logic [1:0] idx;

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      // NOTE: every output gets a default before any conditional write,
      // otherwise the tool infers a latch for the unassigned paths.
      gnt_onehot = 3'b000;
      idx        = 2'd0;
      for (int k = 3; k >= 1; k--) begin
         idx = 2'((int'(ptr) + k) % 3);
         if (req[idx]) begin
            gnt_onehot      = 3'b000;
            gnt_onehot[idx] = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/ahb_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_arbiter
// Round-robin arbiter sharing one AHB bus between three masters. Grants are
// re-evaluated every cycle in ARB, frozen for the length of a fixed burst
// (BURST) or while the owner holds its lock (LOCKED).
//   HCLK   : bus clock
//   HRESET : synchronous active-high reset
//   bus    : arbitration interface (slave side)
// ----------------------------------------------------------------------------
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int NUM_M = 3,
   parameter int DEF_M = 0
) (
   input logic          HCLK,
   input logic          HRESET,
   ahb_arbiter_if.slave bus
);

   localparam logic [NUM_M-1:0] DEF_GNT = NUM_M'(1 << DEF_M);

   arb_state_t       state;
   logic [3:0]       cnt;
   logic [3:0]       cnt_nxt;
   logic [1:0]       ptr;
   logic [NUM_M-1:0] hgrant;
   logic [1:0]       hmaster;
   logic [1:0]       hmaster_d;
   logic             hmastlock;

   logic [2:0]       pick_gnt;
   logic             pick_valid;
   logic [1:0]       pick_idx;
   logic [1:0]       gnt_idx;
   logic             owner_lock;
   logic             rearb;

   rr_pick3 u_pick (
      .req        (bus.HBUSREQ),
      .ptr        (ptr),
      .gnt_onehot (pick_gnt),
      .valid      (pick_valid)
   );

   assign gnt_idx    = onehot_to_idx(hgrant);
   assign pick_idx   = onehot_to_idx(pick_gnt);
   assign owner_lock = bus.HLOCK[gnt_idx];

   // Beat counter: loaded by a fixed-burst NONSEQ, stepped by accepted SEQ
   // beats, held by BUSY and wait states. A NONSEQ or IDLE inside a burst
   // terminates it; the new NONSEQ is then handled as a fresh ARB transfer.
   always_comb begin
      cnt_nxt = cnt;
      if (bus.HREADY) begin
         case (bus.HTRANS)
            HT_NONSEQ: cnt_nxt = (state == BURST) ? 4'd0 : burst_beats(bus.HBURST);
            HT_SEQ:    if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
            HT_IDLE:   cnt_nxt = 4'd0;
            default:   cnt_nxt = cnt;
         endcase
      end
   end

   // Re-arbitrate when staying in (or returning to) ARB from ARB or LOCKED.
   // A burst that just finished holds the grant one more cycle, so requests
   // seen on the last-beat edge only count in the following ARB cycle.
   assign rearb = (state != BURST) && !owner_lock && (cnt_nxt == 4'd0);

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state     <= ARB;
         cnt       <= 4'd0;
         ptr       <= 2'd0;
         hgrant    <= DEF_GNT;
         hmaster   <= 2'd0;
         hmaster_d <= 2'd0;
         hmastlock <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values (hmaster_d gets old hmaster).
         cnt <= cnt_nxt;

         if (bus.HREADY) begin
            hmaster   <= gnt_idx;
            hmaster_d <= hmaster;
            hmastlock <= owner_lock;
         end

         if (rearb) begin
            hgrant <= pick_valid ? pick_gnt : DEF_GNT;
            if (pick_valid) ptr <= pick_idx;
         end

         case (state)
            ARB: begin
               if (owner_lock)             state <= LOCKED;
               else if (cnt_nxt != 4'd0)   state <= BURST;
            end
            BURST: begin
               if (owner_lock)             state <= LOCKED;
               else if (cnt_nxt == 4'd0)   state <= ARB;
            end
            LOCKED: begin
               if (!owner_lock)            state <= (cnt_nxt != 4'd0) ? BURST : ARB;
            end
            default:                       state <= ARB;
         endcase
      end
   end

   assign bus.HGRANT    = hgrant;
   assign bus.HMASTER   = hmaster;
   assign bus.HMASTER_D = hmaster_d;
   assign bus.HMASTLOCK = hmastlock;

endmodule
